// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - shared widths, note increments and FSM states for voice_mix_sched
package piano_pkg;

  localparam int NVOICE  = 8;
  localparam int PHASE_W = 16;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int SUM_W   = DATA_W + 3;
  localparam int CNT_W   = 4;
  localparam int DIV_STEPS = SUM_W;

  // Phase increment per note; 0x0100 advances the ROM address by one per sample.
  localparam logic [PHASE_W-1:0] NOTE_INC [NVOICE] = '{
    16'h0100, 16'h0200, 16'h0300, 16'h0400,
    16'h0500, 16'h0600, 16'h0700, 16'h0800
  };

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    DRAIN = 3'd2,
    DIV   = 3'd3,
    DONE  = 3'd4
  } state_e;

  function automatic logic [CNT_W-1:0] popcount8(input logic [NVOICE-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NVOICE; i++) n = n + {{(CNT_W-1){1'b0}}, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - fixed 11-cycle restoring divider, 11-bit dividend by 4-bit divisor
module seq_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [10:0] dividend,
  input  logic [3:0]  divisor,
  output logic [10:0] quotient,
  output logic        done
);

  logic [3:0]  rem_q, rem_d, src_rem;
  logic [10:0] quo_q, quo_d, src_quo;
  logic [4:0]  trial;
  logic [3:0]  step_q;
  logic        busy_q, done_q;

  // One restoring step; the start cycle already performs the first step on the raw dividend.
  always_comb begin
    src_rem = start ? 4'd0 : rem_q;
    src_quo = start ? dividend : quo_q;
    trial   = {src_rem, src_quo[10]};
    rem_d   = trial[3:0];
    quo_d   = {src_quo[9:0], 1'b0};
    if (trial >= {1'b0, divisor}) begin
      rem_d = 4'(trial - {1'b0, divisor});
      quo_d = {src_quo[9:0], 1'b1};
    end
  end

  // Step sequencing: start gives step 1, ten more busy cycles complete the quotient.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      step_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem_q  <= rem_d;
        quo_q  <= quo_d;
        step_q <= 4'd1;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q  <= rem_d;
        quo_q  <= quo_d;
        step_q <= step_q + 4'd1;
        if (step_q == 4'd10) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_q;
  assign done     = done_q;

endmodule

// File: rtl/voice_mix_sched.sv
// rtl/voice_mix_sched.sv - per-tick scan of 8 voices through one shared ROM, mixed and normalised
module voice_mix_sched #(
  parameter int NVOICE     = piano_pkg::NVOICE,
  parameter int PHASE_W    = piano_pkg::PHASE_W,
  parameter int ADDR_W     = piano_pkg::ADDR_W,
  parameter int DATA_W     = piano_pkg::DATA_W,
  parameter int SAMPLE_DIV = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NVOICE-1:0] keys,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] wave,
  output logic              wave_valid
);
  import piano_pkg::*;

  localparam int TICK_W = $clog2(SAMPLE_DIV);
  localparam int MIX_W  = DATA_W + 3;

  if (SAMPLE_DIV < 24) begin : g_sample_div_check
    $error("SAMPLE_DIV must be at least 24");
  end

  logic [NVOICE-1:0]  keys_meta_q, keys_sync_q;
  logic [TICK_W-1:0]  tick_cnt_q;
  logic               tick;
  state_e             state_q, state_d;
  logic [3:0]         step_q, step_d;
  logic [2:0]         slot;
  logic [NVOICE-1:0]  act_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [MIX_W-1:0]   sum_q;
  logic               rd_pend_q;
  logic [PHASE_W-1:0] phase_q [NVOICE];
  logic [DATA_W-1:0]  wave_q, quo_sel;
  logic               wave_valid_q;
  logic               div_start, div_done;
  logic [10:0]        div_quo;

  assign tick = (tick_cnt_q == TICK_W'(SAMPLE_DIV - 1));
  assign slot = step_q[2:0];

  // Two-flop synchroniser for the asynchronous key levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keys_meta_q <= '0;
      keys_sync_q <= '0;
    end else begin
      keys_meta_q <= keys;
      keys_sync_q <= keys_meta_q;
    end
  end

  // Free-running sample tick counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_cnt_q <= '0;
    else     tick_cnt_q <= tick ? '0 : tick_cnt_q + TICK_W'(1);
  end

  // FSM state register with its slot/step counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // Frame sequencing: one IDLE cycle, 8 scan slots, drain, fixed-length divide, done.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      IDLE:  if (tick) begin state_d = SCAN; step_d = '0; end
      SCAN:  if (step_q == 4'(NVOICE - 1)) begin state_d = DRAIN; step_d = '0; end
             else step_d = step_q + 4'd1;
      DRAIN: begin state_d = DIV; step_d = '0; end
      DIV:   if (step_q == 4'(DIV_STEPS - 1)) begin state_d = DONE; step_d = '0; end
             else step_d = step_q + 4'd1;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ROM strobe/address during scan, divider kick-off, and quotient selection.
  always_comb begin
    rom_en    = (state_q == SCAN) && act_q[slot];
    rom_addr  = '0;
    if (rom_en) rom_addr = phase_q[slot][PHASE_W-1 -: ADDR_W];
    div_start = (state_q == DIV) && (step_q == 4'd0);
    quo_sel   = '0;
    if (cnt_q != '0 && div_done)
      quo_sel = (|div_quo[10:DATA_W]) ? '1 : div_quo[DATA_W-1:0];
  end

  // Key snapshot, accumulation of returned samples and phase advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q     <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      rd_pend_q <= 1'b0;
      for (int i = 0; i < NVOICE; i++) phase_q[i] <= '0;
    end else begin
      rd_pend_q <= rom_en;
      if (state_q == IDLE && tick) begin
        act_q <= keys_sync_q;
        cnt_q <= popcount8(keys_sync_q);
        sum_q <= '0;
      end else if (rd_pend_q) begin
        sum_q <= sum_q + MIX_W'(rom_data);
      end
      // Released voices park at phase 0 so a fresh press starts at the waveform origin.
      if (state_q == SCAN)
        phase_q[slot] <= act_q[slot] ? phase_q[slot] + PHASE_W'(NOTE_INC[slot]) : '0;
    end
  end

  // Output register: wave holds between frames, valid pulses for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wave_q       <= '0;
      wave_valid_q <= 1'b0;
    end else begin
      wave_valid_q <= (state_q == DONE);
      if (state_q == DONE) wave_q <= quo_sel;
    end
  end

  assign wave       = wave_q;
  assign wave_valid = wave_valid_q;

  seq_divider u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (sum_q),
    .divisor  (cnt_q),
    .quotient (div_quo),
    .done     (div_done)
  );

endmodule

// File: tb/tb_voice_mix_sched.sv
// tb/tb_voice_mix_sched.sv - directed self-checking bench for voice_mix_sched
module tb_voice_mix_sched;

  localparam int SDIV = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] keys;
  logic       rom_en;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] wave;
  logic       wave_valid;

  logic       rom_mode;
  logic [7:0] rom_const;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int en_cnt = 0, en_first = 0, en_last = 0, bad_addr = 0;
  logic [7:0] addr_q [$];

  always #5 clk = ~clk;

  voice_mix_sched #(.SAMPLE_DIV(SDIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .keys       (keys),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .wave       (wave),
    .wave_valid (wave_valid)
  );

  // ROM model: one-cycle read latency, junk when not strobed.
  always @(posedge clk)
    rom_data <= rom_en ? (rom_mode ? rom_addr : rom_const) : 8'hA5;

  // Frame activity monitor.
  always @(negedge clk) begin
    cyc++;
    if (rom_en) begin
      if (en_cnt == 0) en_first = cyc;
      en_last = cyc;
      en_cnt++;
      addr_q.push_back(rom_addr);
    end else if (rom_addr != 8'h00) begin
      bad_addr++;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic clear_stats();
    en_cnt = 0;
    en_first = 0;
    en_last = 0;
    addr_q.delete();
  endtask

  task automatic wait_pulse(output int pc);
    int n;
    n = 0;
    while (n < 3 * SDIV) begin
      @(negedge clk);
      #1;
      n++;
      if (wave_valid) break;
    end
    if (!wave_valid) check("pulse_timeout", 0, 1);
    pc = cyc;
  endtask

  function automatic int addr_pair();
    if (addr_q.size() != 2) return 32'hFFFF_FFFF;
    return {8'd2, addr_q[0], addr_q[1]};
  endfunction

  initial begin
    int pc, pc2, n, seen;
    rst = 1'b1;
    keys = 8'h00;
    rom_mode = 1'b0;
    rom_const = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wave", wave, 0);
    check("rst_valid", wave_valid, 0);
    check("rst_rom_en", rom_en, 0);
    check("rst_rom_addr", rom_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    clear_stats();

    // No keys: zero output, no ROM reads, one pulse per tick period.
    wait_pulse(pc);
    check("idle_wave", wave, 0);
    check("idle_rom_en", en_cnt, 0);
    clear_stats();
    wait_pulse(pc2);
    check("idle_period", pc2 - pc, SDIV);
    check("idle_wave2", wave, 0);

    // Single key, constant 200.
    keys = 8'h01;
    rom_const = 8'd200;
    clear_stats();
    wait_pulse(pc);
    check("k01_wave", wave, 200);
    check("k01_en_cnt", en_cnt, 1);
    check("k01_latency", pc - en_first, 21);
    @(negedge clk);
    #1;
    check("k01_valid_drop", wave_valid, 0);
    check("k01_wave_hold", wave, 200);

    // All keys, full-scale samples.
    keys = 8'hFF;
    rom_const = 8'd255;
    clear_stats();
    wait_pulse(pc);
    check("kff_wave", wave, 255);
    check("kff_en_cnt", en_cnt, 8);
    check("kff_en_run", en_last - en_first, 7);

    // Park phases at 0, then walk two voices through an address-echo ROM.
    keys = 8'h00;
    clear_stats();
    wait_pulse(pc);
    keys = 8'h03;
    rom_mode = 1'b1;
    clear_stats();
    wait_pulse(pc);
    check("k03_f1_addr", addr_pair(), {8'd2, 8'd0, 8'd0});
    check("k03_f1_wave", wave, 0);
    clear_stats();
    wait_pulse(pc);
    check("k03_f2_addr", addr_pair(), {8'd2, 8'd1, 8'd2});
    check("k03_f2_wave", wave, 1);
    clear_stats();
    wait_pulse(pc);
    check("k03_f3_addr", addr_pair(), {8'd2, 8'd2, 8'd4});
    check("k03_f3_wave", wave, 3);

    // Three voices: non-power-of-two divide.
    keys = 8'h07;
    rom_mode = 1'b0;
    rom_const = 8'd100;
    clear_stats();
    wait_pulse(pc);
    check("k07_wave", wave, 100);
    check("k07_en_cnt", en_cnt, 3);

    // Release key 0 for a frame, re-press: it restarts at address 0.
    keys = 8'h06;
    clear_stats();
    wait_pulse(pc);
    check("k06_en_cnt", en_cnt, 2);
    keys = 8'h07;
    rom_mode = 1'b1;
    clear_stats();
    wait_pulse(pc);
    check("repress_addr0", (addr_q.size() > 0) ? int'(addr_q[0]) : -1, 0);

    // Reset during the divide phase aborts the frame.
    rom_mode = 1'b0;
    clear_stats();
    n = 0;
    while (n < 2 * SDIV && !rom_en) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rom_en_seen", rom_en, 1);
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_wave", wave, 0);
    check("midrst_valid", wave_valid, 0);
    check("midrst_rom_en", rom_en, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (wave_valid) seen++;
    end
    check("midrst_no_pulse", seen, 0);
    clear_stats();
    wait_pulse(pc);
    check("postrst_wave", wave, 100);
    check("postrst_en_cnt", en_cnt, 3);

    check("addr_idle_zero", bad_addr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
